// File: rtl/trap_handler.sv
// Machine-mode trap/MRET sequencer: saves trap context into the M-mode CSRs,
// restores interrupt-enable state on MRET, and issues a one-cycle PC redirect.
module trap_handler #(
  parameter logic [31:0] MTVEC_RST      = 32'h0000_0100,
  parameter logic [31:0] MCAUSE_ILLEGAL = 32'd2
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        EN,
  input  logic        trap_req,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_xval,
  input  logic        mret_req,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  o_dbg_state
);

  // Requests are sampled only in IDLE; the upstream stage keeps them asserted
  // while stall_o is high, so anything seen outside IDLE is a repeat.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE     = 2'd1,
    RESTORE  = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_from_trap;
  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;

  logic        w_idle;
  logic        w_take_trap;
  logic        w_take_mret;
  logic        w_csr_write;
  logic [31:0] w_mstatus;

  assign w_idle      = (r_state == IDLE);
  assign w_take_trap = w_idle && EN && trap_req;
  assign w_take_mret = w_idle && EN && mret_req && !trap_req;
  assign w_csr_write = w_idle && csr_we && !w_take_trap && !w_take_mret;
  assign w_mstatus   = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    stall_o        = 1'b0;
    flush_o        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_take_trap) begin
          w_state_nxt = SAVE;
        end else if (w_take_mret) begin
          w_state_nxt = RESTORE;
        end
      end
      SAVE: begin
        stall_o     = 1'b1;
        w_state_nxt = REDIRECT;
      end
      RESTORE: begin
        stall_o     = 1'b1;
        w_state_nxt = REDIRECT;
      end
      REDIRECT: begin
        stall_o        = 1'b1;
        flush_o        = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = r_from_trap ? {r_mtvec[31:2], 2'b00} : r_mepc;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // CSR writes lose to a trap/MRET taken on the same edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_from_trap <= 1'b0;
      r_mie       <= 1'b0;
      r_mpie      <= 1'b0;
      r_mtvec     <= MTVEC_RST;
      r_mepc      <= 32'd0;
      r_mcause    <= 32'd0;
      r_mtval     <= 32'd0;
    end else if (w_take_trap) begin
      r_from_trap <= 1'b1;
      r_mepc      <= {trap_pc[31:2], 2'b00};
      r_mcause    <= MCAUSE_ILLEGAL;
      r_mtval     <= trap_xval;
      r_mpie      <= r_mie;
      r_mie       <= 1'b0;
    end else if (w_take_mret) begin
      r_from_trap <= 1'b0;
      r_mie       <= r_mpie;
      r_mpie      <= 1'b1;
    end else if (w_csr_write) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          r_mie  <= csr_wdata[3];
          r_mpie <= csr_wdata[7];
        end
        ADDR_MTVEC:  r_mtvec  <= {csr_wdata[31:2], 2'b00};
        ADDR_MEPC:   r_mepc   <= {csr_wdata[31:2], 2'b00};
        ADDR_MCAUSE: r_mcause <= csr_wdata;
        ADDR_MTVAL:  r_mtval  <= csr_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = w_mstatus;
      ADDR_MTVEC:   csr_rdata = r_mtvec;
      ADDR_MEPC:    csr_rdata = r_mepc;
      ADDR_MCAUSE:  csr_rdata = r_mcause;
      ADDR_MTVAL:   csr_rdata = r_mtval;
      default:      csr_rdata = 32'd0;
    endcase
  end

endmodule

// File: doc/trap_handler.md
TRAP_HANDLER -- requirements
Module: trap_handler

Interface
REQ-001 SHALL have parameter MTVEC_RST, default 32'h0000_0100: reset value of mtvec.
REQ-002 SHALL have parameter MCAUSE_ILLEGAL, default 32'd2: cause code written on an illegal-instruction trap.
REQ-003 SHALL have port CLK  in  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTn  in  1: reset, asynchronous and active-low.
REQ-005 SHALL have port EN  in  1: block enable; when 0, new trap_req and mret_req are ignored.
REQ-006 SHALL have port trap_req  in  1: decode trap pulse (illegal instruction).
REQ-007 SHALL have port trap_pc  in  32: PC of the trapping instruction.
REQ-008 SHALL have port trap_xval  in  32: offending instruction word.
REQ-009 SHALL have port mret_req  in  1: MRET detected in decode.
REQ-010 SHALL have port csr_we  in  1: CSR write strobe.
REQ-011 SHALL have port csr_addr  in  12: CSR address for read and write.
REQ-012 SHALL have port csr_wdata  in  32: CSR write data.
REQ-013 SHALL have port csr_rdata  out  32: CSR read data.
REQ-014 SHALL have port stall_o  out  1: pipeline hold while a trap or MRET is being serviced.
REQ-015 SHALL have port flush_o  out  1: flush of the fetch/decode stages.
REQ-016 SHALL have port redirect_valid  out  1: PC redirect strobe.
REQ-017 SHALL have port redirect_pc  out  32: new PC value.

Function
REQ-018 SHALL implement the FSM states IDLE, SAVE, RESTORE and REDIRECT.
REQ-019 SHALL go IDLE->SAVE on the edge where EN=1 and trap_req=1.
REQ-020 SHALL go IDLE->RESTORE on the edge where EN=1, mret_req=1 and trap_req=0.
REQ-021 SHALL give trap_req priority when trap_req and mret_req are both 1; the MRET is dropped.
REQ-022 SHALL, on the IDLE->SAVE edge, capture trap_pc into mepc with bits[1:0] forced to 0.
REQ-023 SHALL, on the IDLE->SAVE edge, load MCAUSE_ILLEGAL into mcause and trap_xval into mtval.
REQ-024 SHALL, on the IDLE->SAVE edge, set mstatus.MPIE (bit 7) to mstatus.MIE (bit 3) and clear MIE.
REQ-025 SHALL, on the IDLE->RESTORE edge, set MIE to MPIE and set MPIE to 1.
REQ-026 SHALL go SAVE->REDIRECT and RESTORE->REDIRECT unconditionally after one cycle.
REQ-027 SHALL go REDIRECT->IDLE unconditionally after one cycle.
REQ-028 SHALL drive stall_o=1 in SAVE, RESTORE and REDIRECT, and 0 in IDLE.
REQ-029 SHALL drive redirect_valid=1 and flush_o=1 for exactly the one REDIRECT cycle, and 0 otherwise.
REQ-030 SHALL drive redirect_pc = {mtvec[31:2],2'b00} in REDIRECT when the transition came from SAVE.
REQ-031 SHALL drive redirect_pc = mepc in REDIRECT when the transition came from RESTORE.
REQ-032 SHALL drive redirect_pc = 0 outside REDIRECT.
REQ-033 SHALL give latency from request edge to redirect_valid of exactly 2 cycles, for both traps and MRET.
REQ-034 SHALL ignore trap_req and mret_req when the FSM is not in IDLE; the upstream stage holds its request while stall_o=1.
REQ-035 SHALL map CSRs as: 0x300 mstatus (only bits 3 and 7 writable, others read 0), 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x343 mtval.
REQ-036 SHALL write bits[1:0] of mtvec and mepc as 0.
REQ-037 SHALL return csr_rdata combinationally from csr_addr; unmapped addresses return 0.
REQ-038 SHALL apply csr_we only in IDLE and only when no trap/MRET transition is taken that edge; otherwise the write is discarded.
REQ-039 SHALL make a CSR write to mepc in the cycle before mret_req take effect on the following MRET redirect.

Reset
REQ-040 SHALL, while RSTn=0, asynchronously force the FSM to IDLE.
REQ-041 SHALL, while RSTn=0, force mtvec=MTVEC_RST, and mepc, mcause, mtval and mstatus to 0.
REQ-042 SHALL, while RSTn=0, hold stall_o, flush_o and redirect_valid at 0 and redirect_pc at 0.
REQ-043 SHALL abort any in-progress trap or MRET on reset assertion mid-sequence, with no redirect issued.

Verification
REQ-044 SHALL cover: reset, then trap_req with trap_pc=0x0000_1004 and trap_xval=0xFFFF_FFFF -> 2 cycles later redirect_valid=1 and redirect_pc=0x0000_0100, with mepc=0x1004, mcause=2 and mtval=0xFFFF_FFFF.
REQ-045 SHALL cover: mstatus=0x08, then trap and then mret_req -> mstatus=0x80 after the trap, 0x88 after the MRET, and redirect_pc=0x1004.
REQ-046 SHALL cover: trap_req and mret_req asserted in the same cycle -> trap sequence only, redirect_pc=mtvec, and one redirect pulse.
REQ-047 SHALL cover: csr write mtvec=0x0000_2003, then trap -> mtvec reads 0x2000 and redirect_pc=0x2000.
REQ-048 SHALL cover: RSTn pulled low during SAVE -> no redirect_valid, stall_o=0, and mepc=0.
REQ-049 SHALL cover: EN=0 with trap_req=1 -> state stays IDLE, stall_o=0, and all CSRs unchanged.
